// File: rtl/prog_loader.sv
// UART-framed program loader for the instruction BSRAM.
// Parses SYNC, LEN_HI, LEN_LO, LEN x {hi, lo}, CSUM and writes the words from address 0 upward,
// holding the CPU while loading and muxing the BSRAM address between the loader and the CPU PC.
module prog_loader #(
    parameter int unsigned ADDR_W      = 11,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 2700000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [15:0]       mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCsum
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        sum_q, sum_d;
    // Word counter doubles as the write address; it is one bit wider so a full image reads 2**ADDR_W.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [15:0]       din_q, din_d;
    logic              wre_q, wre_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [15:0]       len_full;

    // Next-state logic: byte-driven frame parser plus inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hi_d     = hi_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        wre_d    = 1'b0;
        hold_d   = hold_q;
        done_d   = 1'b0;
        err_d    = err_q;
        len_full = {len_q[15:8], rx_data};

        // The address advances the cycle after the write pulse, independent of the parser state.
        if (wre_q) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (state_q == StIdle || rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = StLenHi;
                        hold_d  = 1'b1;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        sum_d   = '0;
                    end
                end
                StLenHi: begin
                    len_d[15:8] = rx_data;
                    state_d     = StLenLo;
                end
                StLenLo: begin
                    len_d[7:0] = rx_data;
                    if (len_full == 16'd0 || 32'(len_full) > Depth) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StDataHi;
                    end
                end
                StDataHi: begin
                    hi_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = StDataLo;
                end
                StDataLo: begin
                    sum_d = sum_q + rx_data;
                    din_d = {hi_q, rx_data};
                    wre_d = 1'b1;
                    if (32'(cnt_q) + 32'd1 == 32'(len_q)) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StDataHi;
                    end
                end
                StCsum: begin
                    if (rx_data == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            // Partial image stays in BSRAM; cpu_hold stays asserted.
            err_d   = 1'b1;
            state_d = StIdle;
        end

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            wre_q   <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            wre_q   <= wre_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Loader owns the port while a frame is open or a write is still pending.
    always_comb begin
        mem_ad = (busy_q || wre_q) ? cnt_q[ADDR_W-1:0] : cpu_pc;
    end

    assign mem_ce     = 1'b1;
    assign mem_wre    = wre_q;
    assign mem_din    = din_q;
    assign cpu_hold   = hold_q;
    assign busy       = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign load_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a behavioural BSRAM that records every write pulse.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [10:0] cpu_pc = 11'h000;
    logic        mem_ce, mem_wre;
    logic [10:0] mem_ad;
    logic [15:0] mem_din;
    logic        cpu_hold, busy, load_done, load_err;
    logic [11:0] load_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    prog_loader #(
        .ADDR_W     (11),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cpu_pc    (cpu_pc),
        .mem_ce    (mem_ce),
        .mem_wre   (mem_wre),
        .mem_ad    (mem_ad),
        .mem_din   (mem_din),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    // BSRAM model plus write log.
    logic [15:0] mem [0:2047];
    int unsigned wr_cnt = 0;
    logic [10:0] last_wr = 11'h000;
    always @(posedge clk) begin
        if (mem_ce && mem_wre) begin
            mem[mem_ad] <= mem_din;
            wr_cnt      <= wr_cnt + 1;
            last_wr     <= mem_ad;
        end
    end

    // Strobe one byte; returns #1 after the accepting edge (i.e. in cycle N+1).
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cpu_pc = 11'h155;
        #2;
        n_cmp++;
        if ({mem_ce, mem_wre, cpu_hold, busy, load_done, load_err} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 100000",
                     {mem_ce, mem_wre, cpu_hold, busy, load_done, load_err});
        end
        n_cmp++;
        if (mem_din !== 16'h0000 || load_count !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_data din=%h cnt=%0d want 0/0", mem_din, load_count);
        end
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);
        n_cmp++;
        if (mem_ad !== 11'h155) begin
            n_bad++;
            $display("FAIL reset_mux mem_ad=%h want 155", mem_ad);
        end
    endtask

    task automatic test_good_frame;
        int unsigned w0;
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        n_cmp++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL good_busy busy=%b hold=%b want 1/1", busy, cpu_hold);
        end
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        n_cmp++;
        if (mem_wre !== 1'b1 || mem_ad !== 11'd0 || mem_din !== 16'h1234) begin
            n_bad++;
            $display("FAIL good_wr0 wre=%b ad=%h din=%h want 1/000/1234", mem_wre, mem_ad, mem_din);
        end
        idle_cycles(1);
        n_cmp++;
        if (mem_wre !== 1'b0 || load_count !== 12'd1) begin
            n_bad++;
            $display("FAIL good_pulse wre=%b cnt=%0d want 0/1", mem_wre, load_count);
        end
        send_byte(8'hAB);
        send_byte(8'hCD);
        n_cmp++;
        if (mem_wre !== 1'b1 || mem_ad !== 11'd1 || mem_din !== 16'hABCD) begin
            n_bad++;
            $display("FAIL good_wr1 wre=%b ad=%h din=%h want 1/001/abcd", mem_wre, mem_ad, mem_din);
        end
        // 12+34+AB+CD = 0x1BE -> 0xBE
        send_byte(8'hBE);
        n_cmp++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL good_done done=%b hold=%b busy=%b err=%b want 1/0/0/0",
                     load_done, cpu_hold, busy, load_err);
        end
        idle_cycles(1);
        n_cmp++;
        if (load_done !== 1'b0 || load_count !== 12'd2) begin
            n_bad++;
            $display("FAIL good_after done=%b cnt=%0d want 0/2", load_done, load_count);
        end
        n_cmp++;
        if (mem[0] !== 16'h1234 || mem[1] !== 16'hABCD || wr_cnt - w0 !== 2) begin
            n_bad++;
            $display("FAIL good_mem m0=%h m1=%h writes=%0d want 1234/abcd/2",
                     mem[0], mem[1], wr_cnt - w0);
        end
        cpu_pc = 11'h007;
        #1;
        n_cmp++;
        if (mem_ad !== 11'h007) begin
            n_bad++;
            $display("FAIL good_mux mem_ad=%h want 007", mem_ad);
        end
    endtask

    task automatic test_idle_junk;
        int unsigned w0;
        w0 = wr_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        idle_cycles(2);
        n_cmp++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || load_err !== 1'b0 || wr_cnt !== w0) begin
            n_bad++;
            $display("FAIL idle_junk busy=%b hold=%b err=%b writes=%0d want 0/0/0/0",
                     busy, cpu_hold, load_err, wr_cnt - w0);
        end
    endtask

    task automatic test_bad_csum;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hBF);
        n_cmp++;
        if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_err err=%b hold=%b done=%b busy=%b want 1/1/0/0",
                     load_err, cpu_hold, load_done, busy);
        end
        // Recovery frame: DE AD, checksum 0xDE+0xAD = 0x18B -> 0x8B.
        send_byte(8'hA5);
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_sync_clr err=%b want 0", load_err);
        end
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'h8B);
        n_cmp++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_recover done=%b err=%b hold=%b want 1/0/0",
                     load_done, load_err, cpu_hold);
        end
        idle_cycles(1);
        n_cmp++;
        if (mem[0] !== 16'hDEAD || load_count !== 12'd1) begin
            n_bad++;
            $display("FAIL csum_mem m0=%h cnt=%0d want dead/1", mem[0], load_count);
        end
    endtask

    task automatic test_bad_len;
        int unsigned w0;
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++;
        if (load_err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL len0 err=%b busy=%b hold=%b want 1/0/1", load_err, busy, cpu_hold);
        end
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h01);
        n_cmp++;
        if (load_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL len2049 err=%b busy=%b want 1/0", load_err, busy);
        end
        idle_cycles(2);
        n_cmp++;
        if (wr_cnt !== w0) begin
            n_bad++;
            $display("FAIL len_nowrite writes=%0d want 0", wr_cnt - w0);
        end
    endtask

    task automatic test_timeout;
        int unsigned w0;
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h22);
        idle_cycles(20);
        n_cmp++;
        if (busy !== 1'b1 || load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_early busy=%b err=%b want 1/0", busy, load_err);
        end
        idle_cycles(100);
        n_cmp++;
        if (load_err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_err err=%b busy=%b hold=%b want 1/0/1", load_err, busy, cpu_hold);
        end
        n_cmp++;
        if (wr_cnt - w0 !== 2 || last_wr !== 11'd1 || mem[1] !== 16'h2222 || load_count !== 12'd2)
        begin
            n_bad++;
            $display("FAIL tmo_mem writes=%0d last=%0d m1=%h cnt=%0d want 2/1/2222/2",
                     wr_cnt - w0, last_wr, mem[1], load_count);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        cpu_pc = 11'h3A0;
        rst_n  = 1'b0;
        #2;
        n_cmp++;
        if ({mem_ce, mem_wre, cpu_hold, busy, load_done, load_err} !== 6'b100000 ||
            mem_din !== 16'h0000 || load_count !== 12'd0 || mem_ad !== 11'h3A0) begin
            n_bad++;
            $display("FAIL rst_mid flags=%b din=%h cnt=%0d ad=%h want 100000/0000/0/3a0",
                     {mem_ce, mem_wre, cpu_hold, busy, load_done, load_err},
                     mem_din, load_count, mem_ad);
        end
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        // 9A+BC = 0x156 -> 0x56
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'h56);
        n_cmp++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_reload done=%b hold=%b want 1/0", load_done, cpu_hold);
        end
        idle_cycles(1);
        n_cmp++;
        if (mem[0] !== 16'h9ABC || mem[1] !== 16'h2222) begin
            n_bad++;
            $display("FAIL rst_mem m0=%h m1=%h want 9abc/2222", mem[0], mem[1]);
        end
    endtask

    task automatic test_full_mem;
        int unsigned w0;
        int unsigned bad;
        logic [7:0]  s;
        logic [15:0] w;
        w0 = wr_cnt;
        s  = 8'h00;
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h00);
        for (int i = 0; i < 2048; i++) begin
            w = 16'h4000 + 16'(i);
            s = s + w[15:8] + w[7:0];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(s);
        n_cmp++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("FAIL full_done done=%b err=%b hold=%b want 1/0/0",
                     load_done, load_err, cpu_hold);
        end
        idle_cycles(1);
        n_cmp++;
        if (load_count !== 12'd2048 || wr_cnt - w0 !== 2048 || last_wr !== 11'd2047) begin
            n_bad++;
            $display("FAIL full_count cnt=%0d writes=%0d last=%0d want 2048/2048/2047",
                     load_count, wr_cnt - w0, last_wr);
        end
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            cpu_pc = 11'(i);
            #1;
            if (mem_ad !== 11'(i) || mem[mem_ad] !== 16'h4000 + 16'(i)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL full_readback bad_words=%0d want 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_idle_junk;
        test_bad_csum;
        test_bad_len;
        test_timeout;
        test_reset_mid_frame;
        test_full_mem;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
